// File: rtl/rv32_defs.sv
// Shared RV32 definitions for the front end: word width, NOP encoding,
// default reset vector and the fetch queue entry layout.
package rv32_defs;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {pc, instr} words. Entry slot0 is always the
// head, so the read side needs no pointer. Reset and flush only clear the
// occupancy; stale slot contents are never visible because occ gates them.
module fetch_fifo
  import rv32_defs::*;
#(
  parameter int DATA_W = 2 * XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (occ != 2'd0);
  assign push_ok = push && ((occ != 2'd2) || pop_ok);
  assign head    = slot0;

  // Occupancy: one push and one pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occ <= 2'd0;
    end else if (push_ok && !pop_ok) begin
      occ <= occ + 2'd1;
    end else if (pop_ok && !push_ok) begin
      occ <= occ - 2'd1;
    end
  end

  // Storage: a pop shifts slot1 forward; a push fills the first free slot.
  always_ff @(posedge clk) begin
    if (pop_ok) begin
      slot0 <= (occ == 2'd2) ? slot1 : push_data;
      if ((occ == 2'd2) && push_ok) begin
        slot1 <= push_data;
      end
    end else if (push_ok) begin
      if (occ == 2'd0) begin
        slot0 <= push_data;
      end else begin
        slot1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues word reads to a one-cycle-latency
// instruction memory and hands instructions to decode through a 2-entry
// queue. A redirect pulse drops everything in flight and restarts fetch.
module instr_fetch
  import rv32_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] req_pc_p1;
  logic [1:0]      occ;
  logic [2:0]      credit;
  logic            pop;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Slots already claimed after this cycle's pop; a new request may only
  // go out if its response is guaranteed a free queue entry.
  assign pop     = out_valid && out_ready;
  assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign imem_en = rst_n && !redirect && (credit < 3'd2);
  assign imem_addr = pc;

  // A response that lands in a redirect cycle belongs to the old stream.
  assign push       = inflight && !redirect;
  assign push_entry = '{pc: req_pc_p1, instr: imem_rdata};

  assign out_valid = rst_n && (occ != 2'd0);
  assign out_instr = out_valid ? head.instr : RV_NOP;
  assign out_pc    = out_valid ? head.pc : '0;

  // Program counter: reset vector, redirect target, or advance on issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= word_align(redirect_pc);
    end else if (imem_en) begin
      pc <= pc + 32'd4;
    end
  end

  // Outstanding-request flag; a redirect or reset orphans any response.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect) begin
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
    end
  end

  // Memory stage boundary: remember the address whose data returns next.
  always_ff @(posedge clk) begin
    if (imem_en) begin
      req_pc_p1 <= pc;
    end
  end

  fetch_fifo #(
    .DATA_W(2 * XLEN)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .occ      (occ)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle-exact vector table for startup, stall,
// redirect and wrap; a reset-during-operation sequence; then randomized
// ready/redirect traffic checked against a stream-level model of the
// delivered PC sequence.
module tb_instr_fetch;
  import rv32_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  // Memory contents: a scramble of the address, so instr and pc differ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n       = rst;
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic rd, input logic [31:0] rpc,
                     input logic en, input logic [31:0] addr,
                     input logic vld, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.redir = rd; v.rpc = rpc;
    v.exp_en = en; v.exp_addr = addr; v.exp_valid = vld; v.exp_pc = pc;
    tbl.push_back(v);
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [31:0] pc);
    check32({tag, "_valid"}, {31'b0, out_valid}, {31'b0, vld});
    check32({tag, "_pc"}, out_pc, vld ? pc : 32'h0);
    check32({tag, "_instr"}, out_instr, vld ? mem_word(pc) : RV_NOP);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          idle;
    logic        rdy, rd;
    logic [31:0] rpc;

    rst_n = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // Cycle-by-cycle table, row i applied in cycle i after reset release.
    add(1, 0, 0, 1, 32'h00, 0, 0);           // startup
    add(1, 0, 0, 1, 32'h04, 0, 0);
    add(1, 0, 0, 1, 32'h08, 1, 32'h00);
    add(1, 0, 0, 1, 32'h0C, 1, 32'h04);
    for (int i = 0; i < 5; i++)               // stall 5 cycles
      add(0, 0, 0, 0, 32'h10, 1, 32'h08);
    add(1, 0, 0, 1, 32'h10, 1, 32'h08);       // resume with first pop
    add(1, 0, 0, 1, 32'h14, 1, 32'h0C);
    add(1, 0, 0, 1, 32'h18, 1, 32'h10);
    add(1, 1, 32'h103, 0, 32'h1C, 1, 32'h14); // redirect with transfer
    add(1, 0, 0, 1, 32'h100, 0, 0);
    add(1, 0, 0, 1, 32'h104, 0, 0);
    add(1, 0, 0, 1, 32'h108, 1, 32'h100);
    add(1, 0, 0, 1, 32'h10C, 1, 32'h104);
    add(1, 1, 32'h40, 0, 32'h110, 1, 32'h108); // back-to-back redirects
    add(1, 1, 32'h80, 0, 32'h40, 0, 0);
    add(1, 0, 0, 1, 32'h80, 0, 0);
    add(1, 0, 0, 1, 32'h84, 0, 0);
    add(1, 0, 0, 1, 32'h88, 1, 32'h80);
    add(1, 0, 0, 1, 32'h8C, 1, 32'h84);
    add(1, 1, 32'hFFFF_FFF8, 0, 32'h90, 1, 32'h88); // wrap
    add(1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    add(1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFF8);
    add(1, 0, 0, 1, 32'h4, 1, 32'hFFFF_FFFC);
    add(1, 0, 0, 1, 32'h8, 1, 32'h0);
    add(1, 0, 0, 1, 32'hC, 1, 32'h4);

    // Held in reset: no requests, no output.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0);
      check32("rst_en", {31'b0, imem_en}, 32'h0);
      check_out("rst", 0, 0);
    end

    foreach (tbl[i]) begin
      drive(1, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      check32($sformatf("row%0d_en", i), {31'b0, imem_en}, {31'b0, tbl[i].exp_en});
      check32($sformatf("row%0d_addr", i), imem_addr, tbl[i].exp_addr);
      check_out($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_pc);
    end

    // Reset pulse while a queue entry is held and a response is in flight.
    drive(0, 0, 0, 0);
    check32("midrst_en", {31'b0, imem_en}, 32'h0);
    check32("midrst_valid", {31'b0, out_valid}, 32'h0);
    drive(1, 1, 0, 0);
    check32("postrst_addr", imem_addr, DEFAULT_RESET_PC);
    check32("postrst_en", {31'b0, imem_en}, 32'h1);
    check_out("postrst0", 0, 0);
    drive(1, 1, 0, 0);
    check_out("postrst1", 0, 0);
    drive(1, 1, 0, 0);
    check_out("postrst2", 1, DEFAULT_RESET_PC);
    drive(1, 1, 0, 0);
    check_out("postrst3", 1, DEFAULT_RESET_PC + 32'd4);

    // Random traffic: delivered PCs must form contiguous runs starting at
    // each redirect target, with no gap longer than the refill latency.
    drive(1, 0, 1, 32'h0000_2000);
    exp_pc = 32'h0000_2000;
    idle = 0;
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF0 + $urandom_range(0, 15));
      drive(1, rdy, rd, rpc);
      if (imem_en) check32("rnd_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (out_valid && rdy) begin
        check32("rnd_pc", out_pc, exp_pc);
        check32("rnd_instr", out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end else if (!out_valid) begin
        check32("rnd_idle_pc", out_pc, 32'h0);
        check32("rnd_idle_instr", out_instr, RV_NOP);
      end
      if (out_valid || rd) idle = 0;
      else idle++;
      check32("rnd_bubble_bound", {31'b0, (idle <= 2)}, 32'h1);
      if (rd) exp_pc = {rpc[31:2], 2'b00};
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. It owns the program counter, issues word reads to a synchronous instruction memory with one-cycle read latency, and buffers returned words in a 2-entry queue. It presents one instruction per cycle to decode over a valid/ready handshake. A one-cycle redirect input (branch/jump target from execute) flushes everything in flight and restarts fetch at the new address.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset is synchronous and active-low.
- `imem_en`  out  1: read request this cycle.
- `imem_addr`  out  32: byte address of the request; always word-aligned.
- `imem_rdata`  in  32: read data, valid exactly one cycle after the request.
- `redirect`  in  1: single-cycle pulse requesting a fetch restart.
- `redirect_pc`  in  32: restart address; bits [1:0] are ignored and treated as 0.
- `out_valid`  out  1: `out_instr`/`out_pc` hold a valid fetched instruction.
- `out_ready`  in  1: decode accepts this cycle; a transfer occurs when `out_valid && out_ready`.
- `out_instr`  out  32: instruction word; reads NOP (32'h0000_0013) when `out_valid`=0.
- `out_pc`  out  32: address of `out_instr`; reads 0 when `out_valid`=0.

## Operation
- State:
  - `pc`: next address to request.
  - `inflight`: 1 bit, a request was issued last cycle.
  - 2-entry FIFO of {pc, instr}.
  - Occupancy counter, 0..2.
- Issue rule: `imem_en` = `rst_n && !redirect && (occ + inflight - pop) < 2`, where `pop = out_valid && out_ready`. `imem_addr` = `pc` (combinational from the register).
- On issue: `pc <= pc + 4`, with 32-bit wrap (32'hFFFF_FFFC → 0). `inflight <= imem_en`.
- Response: when `inflight`=1 and no redirect this cycle, push {`pc` of the request, `imem_rdata`} at the edge. The request address is kept in a shadow register. The credit rule guarantees the push never overflows.
- Push and pop in the same cycle are legal at any occupancy 0..2. Occupancy is unchanged when one push and one pop coincide at occupancy 1 or 2. At occupancy 0, the push lands and the pop is impossible, because `out_valid`=0.
- `out_valid` = `occ != 0`. Outputs come from the FIFO head, with no bypass from `imem_rdata`.
- Redirect, in the cycle `redirect`=1:
  - A transfer with `out_valid && out_ready` still completes.
  - No new request is issued.
  - The response arriving this cycle is discarded.
  - At the edge: FIFO cleared, `occ <= 0`, `inflight <= 0`, `pc <= {redirect_pc[31:2], 2'b00}`.
- Back-to-back redirects: each redirect restarts the sequence, and the latest target wins.
- Reset, including mid-operation:
  - At the edge: `pc <= RESET_PC`, `occ <= 0`, `inflight <= 0`.
  - A response arriving in the reset cycle is dropped.
  - Outputs during the cycle `rst_n`=0: `imem_en`=0, `out_valid`=0.
- No state machine beyond the occupancy and inflight counters; no other states.

## Timing
- Cycle 0 = first cycle with `rst_n`=1:
  - `imem_en`=1, `imem_addr`=`RESET_PC`.
  - Data returns in cycle 1 and is pushed.
  - `out_valid`=1 in cycle 2, with `out_pc`=`RESET_PC`.
- Startup latency is 2 cycles. Sustained throughput is 1 instruction/cycle while `out_ready`=1.
- Redirect asserted in cycle R:
  - Target request issued in R+1.
  - `out_valid`=1 with `out_pc`=target in R+3.
  - `out_valid`=0 in R+1 and R+2.
- Stall: with `out_ready`=0 the FIFO fills to 2, then `imem_en` stays 0. When `out_ready` returns, fetch resumes the same cycle as the first pop.

## Structure
- Shared package / header `rv32_defs`: `RV_NOP` (32'h0000_0013), `XLEN` (32), and the default `RESET_PC`.
- One sub-module, `fetch_fifo`: 2-entry, 64-bit-wide synchronous FIFO with push, pop, flush, occupancy, and sync active-low reset.
- `instr_fetch` holds the PC, the inflight/shadow address, and the issue/redirect logic.

## Test plan
- Reset release with `out_ready`=1 and memory word = address:
  - `out_pc` sequence 0, 4, 8, … starting in cycle 2.
  - One instruction per cycle with no bubbles.
- `out_ready`=0 for 5 cycles, then 1:
  - Occupancy saturates at 2 and `imem_en`=0 after the fill.
  - No instruction is lost or duplicated; the PC sequence stays contiguous.
- Redirect to 32'h0000_0103 in a cycle with a transfer:
  - The transferring instruction is delivered.
  - Nothing older appears afterwards.
  - `out_pc`=32'h0000_0100 three cycles later.
- Redirect on two consecutive cycles (targets 0x40, then 0x80):
  - The first instruction delivered after the redirects has `out_pc`=0x80, 3 cycles after the second redirect.
  - No 0x40 instruction is delivered.
- `rst_n` pulsed low for 1 cycle while the FIFO is full and a request is inflight:
  - Next cycle: `out_valid`=0 and `imem_addr`=`RESET_PC`.
  - The stale response is not enqueued.
- PC wrap: redirect to 32'hFFFF_FFF8:
  - Delivered `out_pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
